// File: rtl/axis_replay_pkg.sv
// Shared types for the replaying AXI-Stream packet FIFO.
// Holds the FSM state encoding and the response type encoding.
package axis_replay_pkg;

  typedef enum logic [1:0] {
    ST_SEND      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_t;

  localparam logic RESP_ACK  = 1'b0;
  localparam logic RESP_NACK = 1'b1;

  localparam logic [15:0] REPLAY_MAX = 16'hFFFF;

endpackage

// File: rtl/axis_replay_fifo.sv
// AXI-Stream packet FIFO that holds each packet until the far end
// acks it, and resends it verbatim on a nack.
// Ports:
//   clk, sresetn        : clock, async active-low reset
//   axis_i_*            : slave stream (packet input)
//   axis_o_*            : master stream (registered output)
//   resp_valid/nack     : delivery response, 1 = replay, 0 = release
//   resp_ready          : high while a response is awaited
//   replay_count        : saturating count of accepted nacks
module axis_replay_fifo
  import axis_replay_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int LOG2_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      sresetn,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_tlast,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_tlast,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  input  logic                      resp_valid,
  input  logic                      resp_nack,
  output logic                      resp_ready,
  output logic [15:0]               replay_count
);

  localparam int DW    = 8 * AXIS_BYTES;
  localparam int UW    = AXIS_USER_BITS;
  localparam int WW    = 1 + DW + UW;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int AW    = LOG2_DEPTH;

  logic [WW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit above the address.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] committed_rd_ptr;

  state_t state;
  state_t state_nxt;

  logic          full;
  logic          wr_en;
  logic          load;
  logic          o_hs;
  logic          ack;
  logic          nack;
  logic [WW-1:0] rd_word;

  // Space is only reclaimed on ack, so fullness is
  // measured against the committed pointer.
  assign full =
    (wr_ptr[AW-1:0] == committed_rd_ptr[AW-1:0]) &&
    (wr_ptr[AW] != committed_rd_ptr[AW]);

  assign axis_i_tready = !full;
  assign wr_en   = axis_i_tvalid && !full;
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign o_hs    = axis_o_tvalid && axis_o_tready;
  assign resp_ready = (state == ST_WAIT_RESP);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack       = 1'b0;
    nack      = 1'b0;
    unique case (state)
      ST_SEND: begin
        if ((rd_ptr != wr_ptr) &&
            (!axis_o_tvalid || axis_o_tready)) begin
          load = 1'b1;
          if (rd_word[WW-1]) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Only the tlast word can be pending here.
        if (o_hs) state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (resp_valid) begin
          if (resp_nack == RESP_NACK) nack = 1'b1;
          else                        ack  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <=
        {axis_i_tlast, axis_i_tdata, axis_i_tuser};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      {axis_o_tlast, axis_o_tdata, axis_o_tuser} <= rd_word;
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      committed_rd_ptr <= '0;
      state            <= ST_SEND;
      axis_o_tvalid    <= 1'b0;
      replay_count     <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (load)      rd_ptr <= rd_ptr + 1'b1;
      else if (nack) rd_ptr <= committed_rd_ptr;
      if (ack) committed_rd_ptr <= rd_ptr;
      if (load)      axis_o_tvalid <= 1'b1;
      else if (o_hs) axis_o_tvalid <= 1'b0;
      if (nack && (replay_count != REPLAY_MAX)) begin
        replay_count <= replay_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_replay_fifo.sv
// Self-checking bench for axis_replay_fifo (depth 4 words).
// Directed scenarios plus a randomized scoreboard run.
module tb_axis_replay_fifo;

  logic       clk = 1'b0;
  logic       sresetn = 1'b0;
  logic [7:0] axis_i_tdata = '0;
  logic [0:0] axis_i_tuser = '0;
  logic       axis_i_tlast = 1'b0;
  logic       axis_i_tvalid = 1'b0;
  logic       axis_i_tready;
  logic [7:0] axis_o_tdata;
  logic [0:0] axis_o_tuser;
  logic       axis_o_tlast;
  logic       axis_o_tvalid;
  logic       axis_o_tready = 1'b0;
  logic       resp_valid = 1'b0;
  logic       resp_nack = 1'b0;
  logic       resp_ready;
  logic [15:0] replay_count;

  int checks = 0;
  int errors = 0;
  int nack_total = 0;

  bit         mon_en = 1'b0;
  logic [9:0] obs_q[$];

  axis_replay_fifo #(
    .AXIS_BYTES(1),
    .AXIS_USER_BITS(1),
    .LOG2_DEPTH(2)
  ) dut (
    .clk(clk),
    .sresetn(sresetn),
    .axis_i_tdata(axis_i_tdata),
    .axis_i_tuser(axis_i_tuser),
    .axis_i_tlast(axis_i_tlast),
    .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tready(axis_i_tready),
    .axis_o_tdata(axis_o_tdata),
    .axis_o_tuser(axis_o_tuser),
    .axis_o_tlast(axis_o_tlast),
    .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tready(axis_o_tready),
    .resp_valid(resp_valid),
    .resp_nack(resp_nack),
    .resp_ready(resp_ready),
    .replay_count(replay_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && sresetn && axis_o_tvalid && axis_o_tready)
      obs_q.push_back({axis_o_tlast, axis_o_tdata, axis_o_tuser});
  end

  function automatic logic [9:0] wd(logic [7:0] d, logic l);
    return {l, d, d[0]};
  endfunction

  function automatic logic [15:0] sat16(int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [7:0] d, input logic l,
                          output bit ok);
    bit hs;
    axis_i_tdata  = d;
    axis_i_tuser  = d[0];
    axis_i_tlast  = l;
    axis_i_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      hs = axis_i_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    axis_i_tvalid = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (resp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic nk);
    resp_valid = 1'b1;
    resp_nack  = nk;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    resp_nack  = 1'b0;
    if (nk) nack_total++;
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sresetn = 1'b1;
    tick();
    checks++;
    if (axis_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got %b want 1", axis_i_tready);
    end
    checks++;
    if (axis_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tvalid got %b want 0", axis_o_tvalid);
    end
    checks++;
    if (resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp_ready got %b want 0", resp_ready);
    end
    checks++;
    if (replay_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_replay got %0d want 0", replay_count);
    end
  endtask

  task automatic test_single_ack();
    bit ok;
    bit all_ok;
    logic [9:0] exp[3];
    exp[0] = wd(8'h11, 1'b0);
    exp[1] = wd(8'h22, 1'b0);
    exp[2] = wd(8'h33, 1'b1);
    obs_q.delete();
    mon_en = 1'b1;
    axis_o_tready = 1'b1;
    all_ok = 1'b1;
    put_word(8'h11, 1'b0, ok); all_ok &= ok;
    put_word(8'h22, 1'b0, ok); all_ok &= ok;
    put_word(8'h33, 1'b1, ok); all_ok &= ok;
    wait_resp(ok); all_ok &= ok;
    checks++;
    if (!all_ok) begin
      errors++;
      $display("FAIL ack_handshake got timeout want progress");
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL ack_count got %0d want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL ack_word%0d got %h want %h",
                 i, obs_q[i], exp[i]);
      end
    end
    checks++;
    if (axis_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL ack_tready got %b want 1", axis_i_tready);
    end
    respond(1'b0);
    checks++;
    if (resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL ack_resp_drop got %b want 0", resp_ready);
    end
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL ack_no_resend got %0d want 3", obs_q.size());
    end
    checks++;
    if (axis_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL ack_tready_after got %b want 1", axis_i_tready);
    end
  endtask

  task automatic test_latency();
    bit ok;
    axis_o_tready = 1'b1;
    axis_i_tdata  = 8'h5A;
    axis_i_tuser  = 1'b0;
    axis_i_tlast  = 1'b1;
    axis_i_tvalid = 1'b1;
    tick();
    axis_i_tvalid = 1'b0;
    checks++;
    if (axis_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge_n got %b want 0", axis_o_tvalid);
    end
    tick();
    checks++;
    if (axis_o_tvalid !== 1'b1 || axis_o_tdata !== 8'h5A) begin
      errors++;
      $display("FAIL lat_edge_n1 got %b/%h want 1/5a",
               axis_o_tvalid, axis_o_tdata);
    end
    wait_resp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lat_resp got timeout want resp_ready");
    end
    respond(1'b0);
  endtask

  task automatic test_nack_replay();
    bit ok;
    bit all_ok;
    logic [7:0] d[6];
    d = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    obs_q.delete();
    axis_o_tready = 1'b1;
    all_ok = 1'b1;
    put_word(8'h11, 1'b0, ok); all_ok &= ok;
    put_word(8'h22, 1'b0, ok); all_ok &= ok;
    put_word(8'h33, 1'b1, ok); all_ok &= ok;
    wait_resp(ok); all_ok &= ok;
    respond(1'b1);
    wait_resp(ok); all_ok &= ok;
    respond(1'b0);
    checks++;
    if (!all_ok) begin
      errors++;
      $display("FAIL nack_handshake got timeout want progress");
    end
    checks++;
    if (obs_q.size() != 6) begin
      errors++;
      $display("FAIL nack_count got %0d want 6", obs_q.size());
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== wd(d[i], (i % 3) == 2)) begin
        errors++;
        $display("FAIL nack_word%0d got %h want %h",
                 i, obs_q[i], wd(d[i], (i % 3) == 2));
      end
    end
    checks++;
    if (replay_count !== sat16(nack_total)) begin
      errors++;
      $display("FAIL nack_replay_count got %0d want %0d",
               replay_count, sat16(nack_total));
    end
  endtask

  task automatic test_full();
    bit ok;
    bit all_ok;
    obs_q.delete();
    axis_o_tready = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put_word(8'hA0 + 8'(i), i == 3, ok);
      all_ok &= ok;
    end
    checks++;
    if (axis_i_tready !== 1'b0) begin
      errors++;
      $display("FAIL full_tready_low got %b want 0", axis_i_tready);
    end
    wait_resp(ok); all_ok &= ok;
    checks++;
    if (axis_i_tready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold got %b want 0", axis_i_tready);
    end
    respond(1'b0);
    checks++;
    if (axis_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL full_release got %b want 1", axis_i_tready);
    end
    checks++;
    if (!all_ok || obs_q.size() != 4) begin
      errors++;
      $display("FAIL full_words got %0d want 4", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit all_ok;
    logic [9:0] exp[4];
    exp[0] = wd(8'hC1, 1'b0);
    exp[1] = wd(8'hC2, 1'b1);
    exp[2] = wd(8'hD1, 1'b0);
    exp[3] = wd(8'hD2, 1'b1);
    obs_q.delete();
    axis_o_tready = 1'b1;
    all_ok = 1'b1;
    put_word(8'hC1, 1'b0, ok); all_ok &= ok;
    put_word(8'hC2, 1'b1, ok); all_ok &= ok;
    put_word(8'hD1, 1'b0, ok); all_ok &= ok;
    put_word(8'hD2, 1'b1, ok); all_ok &= ok;
    wait_resp(ok); all_ok &= ok;
    repeat (4) tick();
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_hold got %0d want 2", obs_q.size());
    end
    respond(1'b0);
    wait_resp(ok); all_ok &= ok;
    checks++;
    if (!all_ok || obs_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_word%0d got %h want %h",
                 i, obs_q[i], exp[i]);
      end
    end
    respond(1'b0);
  endtask

  task automatic test_random_replay();
    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic [9:0] want;
    int idx = 0;
    int plen;
    int pk_sent = 0;
    int in_left = 0;
    bit acc;
    bit done = 1'b0;
    mon_en = 1'b0;
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      if (!axis_i_tvalid && pk_sent < 300 &&
          $urandom_range(0, 3) != 0) begin
        if (in_left == 0) in_left = $urandom_range(1, 4);
        axis_i_tdata  = 8'($urandom);
        axis_i_tuser  = 1'($urandom);
        axis_i_tlast  = (in_left == 1);
        axis_i_tvalid = 1'b1;
      end
      axis_o_tready = 1'($urandom_range(0, 1));
      resp_valid    = 1'($urandom_range(0, 1));
      resp_nack     = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (axis_o_tvalid && axis_o_tready) begin
        got  = {axis_o_tlast, axis_o_tdata, axis_o_tuser};
        want = (idx < exp_q.size()) ? exp_q[idx] : 10'h3FF;
        checks++;
        if (idx >= exp_q.size() || got !== want) begin
          errors++;
          $display("FAIL rand_word idx %0d got %h want %h",
                   idx, got, want);
        end
        idx++;
      end
      acc = axis_i_tvalid && axis_i_tready;
      if (acc) begin
        exp_q.push_back({axis_i_tlast, axis_i_tdata,
                         axis_i_tuser});
        in_left--;
        if (axis_i_tlast) pk_sent++;
      end
      if (resp_ready && resp_valid) begin
        plen = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (exp_q[k][9]) begin
            plen = k + 1;
            break;
          end
        end
        checks++;
        if (plen == 0 || idx != plen) begin
          errors++;
          $display("FAIL rand_resp_point got %0d want %0d",
                   idx, plen);
        end
        if (resp_nack) nack_total++;
        else repeat (plen) void'(exp_q.pop_front());
        idx = 0;
      end
      @(posedge clk);
      #1;
      if (acc) axis_i_tvalid = 1'b0;
      if (pk_sent == 300 && exp_q.size() == 0) done = 1'b1;
    end
    axis_i_tvalid = 1'b0;
    resp_valid    = 1'b0;
    resp_nack     = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rand_timeout got %0d pkts want 300", pk_sent);
    end
    checks++;
    if (replay_count !== sat16(nack_total)) begin
      errors++;
      $display("FAIL rand_replay_count got %0d want %0d",
               replay_count, sat16(nack_total));
    end
  endtask

  task automatic test_reset_drain();
    bit ok;
    bit all_ok;
    mon_en = 1'b1;
    obs_q.delete();
    axis_o_tready = 1'b0;
    put_word(8'h99, 1'b1, all_ok);
    tick();
    checks++;
    if (axis_o_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstd_pre_tvalid got %b want 1", axis_o_tvalid);
    end
    checks++;
    if (replay_count !== sat16(nack_total)) begin
      errors++;
      $display("FAIL rstd_pre_replay got %0d want %0d",
               replay_count, sat16(nack_total));
    end
    #2;
    sresetn = 1'b0;
    #1;
    checks++;
    if (axis_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstd_tvalid got %b want 0", axis_o_tvalid);
    end
    checks++;
    if (replay_count !== 16'd0) begin
      errors++;
      $display("FAIL rstd_replay got %0d want 0", replay_count);
    end
    nack_total = 0;
    repeat (2) @(posedge clk);
    #1;
    sresetn = 1'b1;
    obs_q.delete();
    axis_o_tready = 1'b1;
    tick();
    checks++;
    if (axis_i_tready !== 1'b1) begin
      errors++;
      $display("FAIL rstd_tready got %b want 1", axis_i_tready);
    end
    put_word(8'h77, 1'b0, ok); all_ok &= ok;
    put_word(8'h88, 1'b1, ok); all_ok &= ok;
    wait_resp(ok); all_ok &= ok;
    checks++;
    if (!all_ok || obs_q.size() != 2) begin
      errors++;
      $display("FAIL rstd_fresh_count got %0d want 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== wd(i == 0 ? 8'h77 : 8'h88, i == 1)) begin
        errors++;
        $display("FAIL rstd_fresh%0d got %h want %h", i, obs_q[i],
                 wd(i == 0 ? 8'h77 : 8'h88, i == 1));
      end
    end
    respond(1'b0);
  endtask

  initial begin
    test_reset();
    test_single_ack();
    test_latency();
    test_nack_replay();
    test_full();
    test_back_to_back();
    test_random_replay();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
